// File: rtl/btn_toggle_bank_pkg.sv
// Shared mode encoding and timing defaults for the button/LED front end.
// Also provides the counter-width helper used by the debounce, pulse and blink counters.
package btn_pkg;

    typedef enum logic [1:0] {
        MODE_TOGGLE    = 2'b00,
        MODE_MOMENTARY = 2'b01,
        MODE_PULSE     = 2'b10,
        MODE_BLINK     = 2'b11
    } mode_e;

    localparam int DEF_N_CH         = 2;
    localparam int DEF_DB_CYCLES    = 120000;
    localparam int DEF_PULSE_CYCLES = 1200000;
    localparam int DEF_BLINK_HALF   = 3000000;

    // Width needed to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_toggle_bank_if.sv
// Button/LED pin bundle: raw buttons and mode in, LED drive, press pulses and debounced levels out.
// master drives btn/mode (board or bench side); slave is the btn_toggle_bank itself.
interface btn_toggle_bank_if #(
    parameter int N_CH = 2
);
    import btn_pkg::*;

    logic [N_CH-1:0] btn;
    mode_e           mode;
    logic [N_CH-1:0] led;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] db_level;

    modport master (output btn, output mode, input led, input press, input db_level);
    modport slave  (input btn, input mode, output led, output press, output db_level);

endinterface

// File: rtl/btn_toggle_bank_debounce.sv
// One channel: 2-FF synchroniser, stable-count debounce filter, registered rising-edge press pulse.
// Latency: pin to db_level 2+DB_CYCLES edges, press one edge after db_level rises.
// Backpressure: none; the pin is sampled every cycle.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic btn,
    output logic db_level,
    output logic press
);

    localparam int                 DBC_W   = cnt_w(DB_CYCLES);
    localparam logic [DBC_W-1:0]   DBC_MAX = DBC_W'(DB_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             lvl_q, lvl_d;
    logic             lvl_dly_q, lvl_dly_d;
    logic             press_q, press_d;
    logic [DBC_W-1:0] dbc_q, dbc_d;

    always_comb begin
        s1_d      = btn;
        s2_d      = s1_q;
        lvl_d     = lvl_q;
        dbc_d     = dbc_q;
        lvl_dly_d = lvl_q;
        press_d   = lvl_q & ~lvl_dly_q;
        // Any sample agreeing with the accepted level restarts the count.
        if (s2_q == lvl_q) begin
            dbc_d = '0;
        end else if (dbc_q == DBC_MAX) begin
            lvl_d = s2_q;
            dbc_d = '0;
        end else begin
            dbc_d = dbc_q + 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            lvl_q     <= 1'b0;
            lvl_dly_q <= 1'b0;
            press_q   <= 1'b0;
            dbc_q     <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            lvl_q     <= lvl_d;
            lvl_dly_q <= lvl_dly_d;
            press_q   <= press_d;
            dbc_q     <= dbc_d;
        end
    end

    assign db_level = lvl_q;
    assign press    = press_q;

endmodule

// File: rtl/btn_toggle_bank.sv
// N-channel button front end: debounced press pulses drive LEDs in toggle/momentary/pulse/blink mode.
// Latency: led follows press (toggle/pulse/blink) or db_level (momentary) by one edge.
// Backpressure: none; all channels run every cycle and are independent.
module btn_toggle_bank
    import btn_pkg::*;
#(
    parameter int N_CH         = DEF_N_CH,
    parameter int DB_CYCLES    = DEF_DB_CYCLES,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int BLINK_HALF   = DEF_BLINK_HALF
) (
    input  logic              sysclk,
    input  logic              rst_n,
    btn_toggle_bank_if.slave  io
);

    localparam int              PC_W    = cnt_w(PULSE_CYCLES + 1);
    localparam int              BC_W    = cnt_w(BLINK_HALF);
    localparam logic [PC_W-1:0] PC_LOAD = PC_W'(PULSE_CYCLES);
    localparam logic [BC_W-1:0] BC_MAX  = BC_W'(BLINK_HALF - 1);

    logic [N_CH-1:0] db;
    logic [N_CH-1:0] press;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_debounce (
            .sysclk   (sysclk),
            .rst_n    (rst_n),
            .btn      (io.btn[gi]),
            .db_level (db[gi]),
            .press    (press[gi])
        );
    end

    logic [BC_W-1:0]            bc_q, bc_d;
    logic                       phase_q, phase_d;
    logic [N_CH-1:0]            tog_q, tog_d;
    logic [N_CH-1:0]            led_q, led_d;
    logic [N_CH-1:0][PC_W-1:0]  pc_q, pc_d;

    always_comb begin
        bc_d    = (bc_q == BC_MAX) ? '0 : bc_q + 1'b1;
        phase_d = phase_q ^ (bc_q == BC_MAX);

        tog_d = tog_q;
        if (io.mode == MODE_TOGGLE || io.mode == MODE_BLINK) begin
            tog_d = tog_q ^ press;
        end

        pc_d  = '0;
        led_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            // Pulse counter only lives while PULSE is selected; a press reloads rather than extends.
            if (io.mode == MODE_PULSE) begin
                if (press[i]) begin
                    pc_d[i] = PC_LOAD;
                end else if (pc_q[i] != '0) begin
                    pc_d[i] = pc_q[i] - 1'b1;
                end
            end
            case (io.mode)
                MODE_TOGGLE:    led_d[i] = tog_d[i];
                MODE_MOMENTARY: led_d[i] = db[i];
                MODE_PULSE:     led_d[i] = (pc_d[i] != '0);
                MODE_BLINK:     led_d[i] = tog_d[i] & phase_d;
                default:        led_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            bc_q    <= '0;
            phase_q <= 1'b0;
            tog_q   <= '0;
            led_q   <= '0;
            pc_q    <= '0;
        end else begin
            bc_q    <= bc_d;
            phase_q <= phase_d;
            tog_q   <= tog_d;
            led_q   <= led_d;
            pc_q    <= pc_d;
        end
    end

    assign io.led      = led_q;
    assign io.press    = press;
    assign io.db_level = db;

endmodule

// File: tb/tb_btn_toggle_bank.sv
// Bench for btn_toggle_bank: directed scenarios then random pins/modes/resets against a reference model.
module tb_btn_toggle_bank;
    import btn_pkg::*;

    localparam int N  = 2;
    localparam int DB = 4;
    localparam int PC = 8;
    localparam int BH = 3;
    localparam int NEVER = -1000000;

    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;
    always #5 sysclk = ~sysclk;

    btn_toggle_bank_if #(.N_CH(N)) io ();

    btn_toggle_bank #(
        .N_CH         (N),
        .DB_CYCLES    (DB),
        .PULSE_CYCLES (PC),
        .BLINK_HALF   (BH)
    ) dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .io     (io)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: pin samples per edge, and output values after each edge.
    logic [N-1:0] hist [0:DB];
    logic [N-1:0] m_db, m_dbq, m_press, m_tog, m_led;
    int           n_edges;
    int           last_load [N];
    logic [N-1:0] press_seen;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] db_o, dbq_o, press_o;
        logic         phase;
        logic         all_opp;
        if (!rst_n) begin
            for (int k = 0; k <= DB; k++) hist[k] = '0;
            m_db = '0; m_dbq = '0; m_press = '0; m_tog = '0; m_led = '0;
            n_edges = 0;
            for (int i = 0; i < N; i++) last_load[i] = NEVER;
        end else begin
            n_edges++;
            db_o = m_db; dbq_o = m_dbq; press_o = m_press;
            // The level flips once the last DB synchronised samples all disagree with it.
            for (int i = 0; i < N; i++) begin
                all_opp = 1'b1;
                for (int k = 1; k <= DB; k++)
                    if (hist[k][i] == db_o[i]) all_opp = 1'b0;
                if (all_opp) m_db[i] = ~db_o[i];
            end
            m_dbq   = db_o;
            m_press = db_o & ~dbq_o;
            if (io.mode == MODE_TOGGLE || io.mode == MODE_BLINK) m_tog = m_tog ^ press_o;
            phase = ((n_edges / BH) % 2) == 1;
            for (int i = 0; i < N; i++) begin
                if (io.mode != MODE_PULSE) last_load[i] = NEVER;
                else if (press_o[i])        last_load[i] = n_edges;
                case (io.mode)
                    MODE_TOGGLE:    m_led[i] = m_tog[i];
                    MODE_MOMENTARY: m_led[i] = db_o[i];
                    MODE_PULSE:     m_led[i] = (n_edges - last_load[i]) < PC;
                    default:        m_led[i] = m_tog[i] & phase;
                endcase
            end
            for (int k = DB; k >= 1; k--) hist[k] = hist[k-1];
            hist[0] = io.btn;
        end
    endtask

    task automatic tick(input string tag);
        @(posedge sysclk);
        model_edge();
        #1;
        check({tag, ".db_level"}, io.db_level, m_db);
        check({tag, ".press"},    io.press,    m_press);
        check({tag, ".led"},      io.led,      m_led);
        press_seen = press_seen | io.press;
    endtask

    task automatic run(input int cycles, input string tag);
        for (int c = 0; c < cycles; c++) tick(tag);
    endtask

    initial begin
        io.btn  = '0;
        io.mode = MODE_TOGGLE;
        rst_n   = 1'b0;
        press_seen = '0;
        tick("reset");
        check("reset_outputs_zero", io.led | io.press | io.db_level, '0);
        run(1, "reset");
        rst_n = 1'b1;
        run(3, "idle");

        // Bounce rejection: 3 high, 1 low, 3 high never reaches the filter's threshold.
        press_seen = '0;
        io.btn[0] = 1'b1; run(3, "bounce");
        io.btn[0] = 1'b0; run(1, "bounce");
        io.btn[0] = 1'b1; run(3, "bounce");
        io.btn[0] = 1'b0; run(8, "bounce");
        check("bounce_no_press", press_seen, '0);
        check("bounce_no_level", io.db_level, '0);

        // Toggle: two clean presses on ch0.
        io.btn[0] = 1'b1; run(10, "toggle1");
        check("toggle_led_on", io.led, 2'b01);
        io.btn[0] = 1'b0; run(10, "toggle_rel");
        io.btn[0] = 1'b1; run(10, "toggle2");
        check("toggle_led_off", io.led, 2'b00);
        io.btn[0] = 1'b0; run(10, "toggle_rel");

        // Momentary on ch1.
        io.mode = MODE_MOMENTARY;
        io.btn[1] = 1'b1; run(20, "mom_hold");
        check("mom_led_on", io.led, 2'b10);
        io.btn[1] = 1'b0; run(10, "mom_rel");
        check("mom_led_off", io.led, 2'b00);

        // Pulse with a retrigger as soon as the filter allows.
        io.mode = MODE_PULSE;
        io.btn[0] = 1'b1; run(6, "pulse_p1");
        io.btn[0] = 1'b0; run(5, "pulse_gap");
        io.btn[0] = 1'b1; run(6, "pulse_p2");
        io.btn[0] = 1'b0; run(16, "pulse_tail");
        check("pulse_expired", io.led, 2'b00);

        // Blink: both channels armed, then ch0 disarmed.
        io.mode = MODE_BLINK;
        io.btn = 2'b11; run(10, "blink_arm");
        io.btn = 2'b00; run(14, "blink_run");
        io.btn = 2'b01; run(10, "blink_ch0");
        io.btn = 2'b00; run(14, "blink_run2");

        // Reset in the middle of a pulse with the button still held.
        io.mode = MODE_PULSE;
        io.btn[0] = 1'b1; run(9, "rst_pulse");
        check("rst_pulse_led_on", io.led[0], 1'b1);
        rst_n = 1'b0; tick("rst_mid");
        check("rst_mid_zero", io.led | io.press | io.db_level, '0);
        rst_n = 1'b1; run(12, "rst_after");
        io.btn[0] = 1'b0; run(10, "rst_rel");

        // Random pins, occasional mode changes and resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 6) == 0) io.btn[i] = ~io.btn[i];
            if ($urandom_range(0, 60) == 0) io.mode = mode_e'(2'($urandom_range(0, 3)));
            rst_n = ($urandom_range(0, 400) != 0);
            tick("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
